// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback scheduler.
//   AW       - register address width
//   DW       - register data width
//   NREG     - number of architectural registers
//   ZERO_REG - hardwired-zero register address
//   src_e    - writeback source index (ALU = port 0, load/multiply = port 1)
package rf_pkg;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;
  localparam logic [AW-1:0] ZERO_REG = '0;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset
//   req[1:0] : request per source (already masked by the caller when needed)
//   grant[1:0]: one-hot (or zero) grant, combinational from req and last
//   last     : most recently granted source
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output src_e       last
);

  // A lone requester always wins; on contention the source that did not
  // win last time gets the grant.
  always_comb begin
    grant    = 2'b00;
    grant[0] = req[0] && (!req[1] || (last == SRC_LSU));
    grant[1] = req[1] && (!req[0] || (last == SRC_ALU));
  end

  // Reset to LSU so that the ALU wins the first contest.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= SRC_LSU;
    end else if (grant[0]) begin
      last <= SRC_ALU;
    end else if (grant[1]) begin
      last <= SRC_LSU;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback scheduler for the 32x32 register file. Shares the single write
// port between the ALU (source 0) and the load/multiply unit (source 1) and
// keeps the busy scoreboard used by issue for RAW/WAW stalls.
//   iss_valid/iss_rd/iss_ready : issue handshake; ready when rd is free
//   q1/q2_addr, q1/q2_busy      : source-register hazard queries
//   wbN_valid/addr/data/ready   : writeback requests, ready = accepted now
//   rf_we/rf_waddr/rf_wdata     : registered write port to the register file
module rf_wb_arbiter
  import rf_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_rd,
  output logic          iss_ready,
  input  logic [AW-1:0] q1_addr,
  input  logic [AW-1:0] q2_addr,
  output logic          q1_busy,
  output logic          q2_busy,
  input  logic          wb0_valid,
  input  logic [AW-1:0] wb0_addr,
  input  logic [DW-1:0] wb0_data,
  output logic          wb0_ready,
  input  logic          wb1_valid,
  input  logic [AW-1:0] wb1_addr,
  input  logic [DW-1:0] wb1_data,
  output logic          wb1_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [1:0]      req;
  logic [1:0]      grant;
  src_e            last;
  logic            grant_any;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic            vld_p1;
  logic [AW-1:0]   waddr_p1;
  logic [DW-1:0]   wdata_p1;

  // Requests are masked during reset so nothing is accepted and the
  // pointer does not move.
  assign req = {wb1_valid, wb0_valid} & {2{!rst}};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant),
    .last  (last)
  );

  assign wb0_ready = grant[0];
  assign wb1_ready = grant[1];
  assign grant_any = |grant;
  assign win_addr  = grant[1] ? wb1_addr : wb0_addr;
  assign win_data  = grant[1] ? wb1_data : wb0_data;

  assign iss_ready = !rst && ((iss_rd == ZERO_REG) || !busy[iss_rd]);
  assign q1_busy   = busy[q1_addr];
  assign q2_busy   = busy[q2_addr];

  // A busy destination blocks issue, so set and clear never collide.
  always_comb begin
    busy_nxt = busy;
    if (vld_p1) begin
      busy_nxt[waddr_p1] = 1'b0;
    end
    if (iss_valid && iss_ready && (iss_rd != ZERO_REG)) begin
      busy_nxt[iss_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Stage p1: registered write port; a grant to register 0 is accepted
  // but never asserts the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else begin
      vld_p1 <= grant_any && (win_addr != ZERO_REG);
      if (grant_any) begin
        waddr_p1 <= win_addr;
        wdata_p1 <= win_data;
      end
    end
  end

  assign rf_we    = vld_p1;
  assign rf_waddr = waddr_p1;
  assign rf_wdata = wdata_p1;

endmodule
